updown_target_sequencer: RTL and testbench

- Shares one external 4-bit up/down counter among NREQ requesters.
- Each requester asks for the counter to be driven to a target value.
- The block arbitrates round-robin, then drives the counter's up/down one step per cycle until cnt equals the latched target, then pulses done to the winner.
- Sits directly in front of the up/down counter block, which it monitors through cnt_in.

---
 rtl/updown_seq_pkg.sv | 43 ++++
 rtl/updown_target_sequencer_rr_arbiter.sv | 37 +++
 rtl/updown_target_sequencer.sv | 107 ++++++++++
 tb/tb_updown_target_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/updown_seq_pkg.sv
// Shared types and direction helper for updown_target_sequencer.
// Define UPDOWN_SEQ_WRAP_SHORTEST_EN to steer along the modular shortest path.
package updown_seq_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Returns {up, down}; operands arrive zero-extended and w is the counter width.
  function automatic logic [1:0] step_dir(input logic [31:0] cnt,
                                          input logic [31:0] tgt,
                                          input int unsigned w);
    logic [31:0] mask;
    logic [31:0] diff;
    logic [1:0]  dir;
    mask = (32'd1 << w) - 32'd1;
    diff = '0;
    dir  = 2'b00;
`ifdef UPDOWN_SEQ_WRAP_SHORTEST_EN
    diff = (tgt - cnt) & mask;
    if (diff == 32'd0)
      dir = 2'b00;
    else if (diff < (32'd1 << (w - 1)))
      dir = 2'b10;
    else
      dir = 2'b01;
`else
    diff = tgt & mask;
    if ((cnt & mask) < diff)
      dir = 2'b10;
    else if ((cnt & mask) > diff)
      dir = 2'b01;
    else
      dir = 2'b00;
`endif
    return dir;
  endfunction

endpackage

// File: rtl/updown_target_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IDXW = $clog2(NREQ);
  localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);

  logic [IDXW:0]   sum;
  logic [IDXW-1:0] pos;
  logic            found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDXW+1)'(k);
      if (sum >= NREQ_W)
        sum = sum - NREQ_W;
      pos = sum[IDXW-1:0];
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        index      = pos;
      end
    end
  end

endmodule

// File: rtl/updown_target_sequencer.sv
// Arbitrates NREQ requesters for one external up/down counter and steps it to the winner's target.
// Optional macro UPDOWN_SEQ_WRAP_SHORTEST_EN selects wrap-around shortest-path stepping.
module updown_target_sequencer
  import updown_seq_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   target,
  input  logic [WIDTH-1:0]        cnt_in,
  output logic                    up,
  output logic                    down,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy
);

  localparam int IDXW = $clog2(NREQ);

  seq_state_t      state, state_next;
  logic [IDXW-1:0] rr_ptr, rr_next;
  logic [IDXW-1:0] idx, idx_next;
  logic [WIDTH-1:0] tgt, tgt_next;

  logic [NREQ-1:0]  arb_grant;
  logic [IDXW-1:0]  arb_index;
  logic [WIDTH-1:0] sel_target;
  logic [NREQ-1:0]  idx_oh;
  logic [IDXW-1:0]  idx_inc;
  logic [1:0]       dir;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .index (arb_index)
  );

  always_comb begin
    sel_target = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_index == IDXW'(i))
        sel_target = target[i*WIDTH +: WIDTH];
  end

  assign idx_oh  = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  assign idx_inc = (idx == IDXW'(NREQ-1)) ? '0 : idx + 1'b1;
  assign dir     = step_dir(32'(cnt_in), 32'(tgt), WIDTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      idx    <= '0;
      tgt    <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
      idx    <= idx_next;
      tgt    <= tgt_next;
    end
  end

  // A withdrawn request wins over stepping: outputs go quiet and the pointer still advances.
  always_comb begin
    state_next = state;
    rr_next    = rr_ptr;
    idx_next   = idx;
    tgt_next   = tgt;
    up         = 1'b0;
    down       = 1'b0;
    gnt        = '0;
    done       = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (|arb_grant) begin
          idx_next   = arb_index;
          tgt_next   = sel_target;
          state_next = STEP;
        end
      end
      STEP: begin
        gnt = idx_oh;
        if (!req[idx]) begin
          rr_next    = idx_inc;
          state_next = IDLE;
        end else begin
          {up, down} = dir;
          if (dir == 2'b00)
            state_next = DONE;
        end
      end
      DONE: begin
        gnt        = idx_oh;
        done       = idx_oh;
        rr_next    = idx_inc;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_updown_target_sequencer.sv
// Directed self-checking bench for updown_target_sequencer with a behavioural up/down counter.
module tb_updown_target_sequencer;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] target;
  logic [3:0]  cnt;
  logic        up, down, busy;
  logic [3:0]  gnt, done;
  logic        load;
  logic [3:0]  load_val;

  int checks;
  int failures;

  updown_target_sequencer #(.NREQ(4), .WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .target  (target),
    .cnt_in  (cnt),
    .up      (up),
    .down    (down),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter the sequencer drives
  always @(posedge clk) begin
    if (load)
      cnt <= load_val;
    else if (up)
      cnt <= cnt + 4'd1;
    else if (down)
      cnt <= cnt - 4'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cnt(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
  endtask

  // Raise req[r] in cycle 0 and observe until its done pulse, then release and idle one cycle.
  task automatic run_req(input int r, input logic [3:0] t,
                         output int ups, output int downs,
                         output int gnt_cyc, output int done_cyc, output logic both);
    ups = 0; downs = 0; gnt_cyc = -1; done_cyc = -1; both = 1'b0;
    target[r*4 +: 4] = t;
    req[r] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (gnt_cyc < 0 && gnt[r]) gnt_cyc = c;
      if (up) ups++;
      if (down) downs++;
      if (up && down) both = 1'b1;
      if (done[r]) begin
        done_cyc = c;
        break;
      end
    end
    req[r] = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = '0; target = '0; load = 1'b0; load_val = '0;
    #2;
    checks++; if ({up, down} !== 2'b00) begin failures++; $display("[TB] FAIL reset_updown got=%b exp=00", {up, down}); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (done !== 4'b0000) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0000", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int ups, downs, gc, dc; logic both;
    load_cnt(4'd3);
    run_req(0, 4'd7, ups, downs, gc, dc, both);
    checks++; if (gc !== 1) begin failures++; $display("[TB] FAIL single_gnt_cycle got=%0d exp=1", gc); end
    checks++; if (ups !== 4) begin failures++; $display("[TB] FAIL single_ups got=%0d exp=4", ups); end
    checks++; if (downs !== 0) begin failures++; $display("[TB] FAIL single_downs got=%0d exp=0", downs); end
    checks++; if (dc !== 6) begin failures++; $display("[TB] FAIL single_done_cycle got=%0d exp=6", dc); end
    checks++; if (cnt !== 4'd7) begin failures++; $display("[TB] FAIL single_cnt got=%0d exp=7", cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_zero_distance();
    int ups, downs, gc, dc; logic both;
    load_cnt(4'd5);
    run_req(3, 4'd5, ups, downs, gc, dc, both);
    checks++; if (ups + downs !== 0) begin failures++; $display("[TB] FAIL zero_steps got=%0d exp=0", ups + downs); end
    checks++; if (dc !== 2) begin failures++; $display("[TB] FAIL zero_done_cycle got=%0d exp=2", dc); end
    checks++; if (gc !== 1) begin failures++; $display("[TB] FAIL zero_gnt_cycle got=%0d exp=1", gc); end
  endtask

  task automatic test_round_robin();
    int order[4];
    int n;
    logic [3:0] pending;
    int exp_order[4];
    exp_order = '{0, 1, 3, 0};
    order = '{-1, -1, -1, -1};
    n = 0;
    pending = '0;
    load_cnt(4'd5);
    target = {4'd5, 4'd5, 4'd5, 4'd5};
    req = 4'b1011;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      step();
      if (|done) begin
        for (int i = 0; i < 4; i++)
          if (done[i]) order[n] = i;
        n++;
        req = req & ~done;
        pending = done;
      end else if (|pending) begin
        req = req | pending;
        pending = '0;
      end
    end
    req = '0;
    step(); step();
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL rr_count got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (order[i] !== exp_order[i]) begin
        failures++; $display("[TB] FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_abort();
    load_cnt(4'd0);
    target[8 +: 4] = 4'd9;
    req[2] = 1'b1;
    step();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL abort_gnt got=%b exp=0100", gnt); end
    checks++; if (up !== 1'b1) begin failures++; $display("[TB] FAIL abort_up1 got=%b exp=1", up); end
    step();
    step();
    req[2] = 1'b0;
    #1;
    checks++; if ({up, down} !== 2'b00) begin failures++; $display("[TB] FAIL abort_quiet got=%b exp=00", {up, down}); end
    checks++; if (cnt !== 4'd2) begin failures++; $display("[TB] FAIL abort_cnt got=%0d exp=2", cnt); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_idle got=%b exp=0", busy); end
    checks++; if (done !== 4'b0000) begin failures++; $display("[TB] FAIL abort_no_done got=%b exp=0000", done); end
    target = {4'd2, 4'd2, 4'd2, 4'd2};
    req = 4'b1111;
    step();
    checks++; if (gnt !== 4'b1000) begin failures++; $display("[TB] FAIL abort_next_gnt got=%b exp=1000", gnt); end
    req = '0;
    step(); step();
  endtask

  task automatic test_down();
    int ups, downs, gc, dc; logic both;
    load_cnt(4'd9);
    run_req(1, 4'd6, ups, downs, gc, dc, both);
    checks++; if (downs !== 3) begin failures++; $display("[TB] FAIL down_downs got=%0d exp=3", downs); end
    checks++; if (ups !== 0) begin failures++; $display("[TB] FAIL down_ups got=%0d exp=0", ups); end
    checks++; if (dc !== 5) begin failures++; $display("[TB] FAIL down_done_cycle got=%0d exp=5", dc); end
    checks++; if (both !== 1'b0) begin failures++; $display("[TB] FAIL down_both got=%b exp=0", both); end
  endtask

  task automatic test_wrap();
    int ups, downs, gc, dc; logic both;
    int exp_ups, exp_downs, exp_dc;
`ifdef UPDOWN_SEQ_WRAP_SHORTEST_EN
    exp_ups = 3; exp_downs = 0; exp_dc = 5;
`else
    exp_ups = 0; exp_downs = 13; exp_dc = 15;
`endif
    load_cnt(4'd14);
    run_req(2, 4'd1, ups, downs, gc, dc, both);
    checks++; if (ups !== exp_ups) begin failures++; $display("[TB] FAIL wrap_ups got=%0d exp=%0d", ups, exp_ups); end
    checks++; if (downs !== exp_downs) begin failures++; $display("[TB] FAIL wrap_downs got=%0d exp=%0d", downs, exp_downs); end
    checks++; if (dc !== exp_dc) begin failures++; $display("[TB] FAIL wrap_done_cycle got=%0d exp=%0d", dc, exp_dc); end
    checks++; if (cnt !== 4'd1) begin failures++; $display("[TB] FAIL wrap_cnt got=%0d exp=1", cnt); end
  endtask

  task automatic test_reset_mid();
    load_cnt(4'd0);
    target[4 +: 4] = 4'd15;
    req[1] = 1'b1;
    step();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL rstmid_gnt got=%b exp=0010", gnt); end
    step(); step();
    reset_n = 1'b0;
    #1;
    checks++; if ({up, down} !== 2'b00) begin failures++; $display("[TB] FAIL rstmid_updown got=%b exp=00", {up, down}); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL rstmid_gnt0 got=%b exp=0000", gnt); end
    checks++; if (done !== 4'b0000) begin failures++; $display("[TB] FAIL rstmid_done got=%b exp=0000", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
    req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_idle got=%b exp=0", busy); end
    target = {cnt, cnt, cnt, cnt};
    req = 4'b1100;
    step();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL rstmid_ptr_gnt got=%b exp=0100", gnt); end
    req = '0;
    step(); step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_zero_distance();
    test_round_robin();
    test_abort();
    test_down();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
